spad_tile_loader: RTL and testbench
===================================

// Module: spad_tile_loader
// PURPOSE
//  Multi-tile scratchpad-to-systolic-array loader for SPAD_X and SPAD_W.
//  Fetches num_tiles tiles of N words from each pad, one read per cycle per pad.
//  Supports programmable stride and SRAM read latency.
//  Double-buffered: the next tile is fetched into staging while the array consumes the
//  committed tile. Sits between the two OpenRAM port-1 read ports and systolic_array.
// PARAMETERS
//  N       4   lanes per tile (words read per pad per tile)
//  AW      6   SPAD address width; addresses wrap mod 2^AW
//  DW      32  data width (FP32)
//  RD_LAT  1   SRAM read latency in cycles, legal range 1..4
//  TW      8   width of tile count
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  start_i        in   1       start pulse; ignored while busy_o=1
//  base_addr_x_i  in   AW      first X address (latched at start)
//  base_addr_w_i  in   AW      first W address (latched at start)
//  stride_x_i     in   AW      X address increment per word (latched at start)
//  stride_w_i     in   AW      W address increment per word (latched at start)
//  num_tiles_i    in   TW      tiles to transfer (latched at start); 0 = no-op
//  csb1_x_o       out  1       SPAD_X read chip select, active-low
//  addr1_x_o      out  AW      SPAD_X read address
//  dout1_x_i      in   DW      SPAD_X read data
//  csb1_w_o       out  1       SPAD_W read chip select, active-low
//  addr1_w_o      out  AW      SPAD_W read address
//  dout1_w_i      in   DW      SPAD_W read data
//  sa_stall_i     in   1       array busy; commit is blocked while high
//  sa_start_o     out  1       one-cycle start pulse to systolic_array
//  sa_x_o         out  N*DW    committed X tile; lane i = [i*DW +: DW]
//  sa_w_o         out  N*DW    committed W tile; lane i = [i*DW +: DW]
//  busy_o         out  1       high whenever state != IDLE
//  done_o         out  1       one-cycle pulse when the final tile is committed
//  tile_cnt_o     out  TW      number of tiles committed since the last start
// BEHAVIOUR
//  Reset (rst=1 at a posedge):
//   - state=IDLE; csb1_*_o=1; addr1_*_o=0.
//   - sa_start_o=0, done_o=0, busy_o=0, tile_cnt_o=0.
//   - sa_x_o, sa_w_o and staging cleared to 0.
//   - Read-valid pipeline cleared; SRAM data still in flight is never captured.
//   - Mid-operation reset aborts the transfer; no done_o is produced.
//  FSM states: IDLE, FETCH, DRAIN, COMMIT.
//  IDLE:
//   - On start_i, latch bases, strides and num_tiles; clear tile_cnt_o.
//   - num_tiles=0: stay in IDLE and pulse done_o in the next cycle; no reads issued.
//   - Otherwise go to FETCH.
//  FETCH (exactly N cycles):
//   - csb1_x_o=csb1_w_o=0; both pads are read in the same cycle.
//   - Request k uses addr=ptr; ptr += stride after each request (wraps mod 2^AW).
//   - ptr carries across tiles: tile t word i sits at base + (t*N+i)*stride.
//  Capture:
//   - A request sampled by the SRAM at edge E is captured into staging[k] at edge E+RD_LAT.
//   - Capture is tracked by an RD_LAT-deep valid/index shift register.
//  DRAIN:
//   - csb high; wait until the last word is captured, then go to COMMIT.
//  COMMIT:
//   - While sa_stall_i=1, hold; no reads are issued and staging is held.
//   - When sa_stall_i=0 at an edge:
//     - sa_x_o/sa_w_o <= staging, sa_start_o=1 for the following cycle only.
//     - tile_cnt_o increments.
//     - If it was the last tile: done_o=1 in the same cycle as sa_start_o, then IDLE.
//     - Otherwise go to FETCH.
//  sa_stall_i is ignored in FETCH and DRAIN, so fetch overlaps computation.
//  sa_x_o/sa_w_o change only on commit and hold their values otherwise.
//  Timing with no stall (start sampled at edge 0):
//   - Requests sampled at edges 1..N; last capture at edge N+RD_LAT.
//   - Commit at edge N+RD_LAT+1; tile period is N+RD_LAT+1 cycles.
//  Inputs changing while busy have no effect.
// TESTING
//  T1: N=4, RD_LAT=1, X[0..3]=1.0,2.0,3.0,4.0 at base 0, W at base 8, stride 1, 1 tile
//      -> addr1_x 0,1,2,3; sa_start_o and done_o high in the cycle after edge 6;
//         sa_x_o lanes = 0x3F800000,0x40000000,0x40400000,0x40800000.
//  T2: 3 tiles, stride_x=2, base_x=60
//      -> X addrs 60,62,0,2,... (wrap); three sa_start_o pulses 6 cycles apart;
//         done_o only with the third pulse; tile_cnt_o=3.
//  T3: hold sa_stall_i=1 for 10 cycles across the first commit
//      -> tile 1 is not committed during stall; sa_x_o holds;
//         tile 2 reads never start; commit occurs the first edge stall=0.
//  T4: RD_LAT=3 build, 1 tile
//      -> data captured 3 edges after each request; commit at edge 8.
//  T5: num_tiles=0 -> no csb low, done_o pulses once, busy_o stays 0;
//      start_i while busy -> ignored, transfer unchanged.
//  T6: assert rst during the FETCH of tile 2
//      -> all outputs 0 next cycle, csb high, no done_o;
//         a new start then runs cleanly from the new base.

Source files
------------

// File: rtl/spad_tile_loader.sv
// Multi-tile loader: streams num_tiles tiles of N words from SPAD_X/SPAD_W into a
// staging buffer and commits each finished tile to the systolic array.
module spad_tile_loader #(
   parameter int N      = 4,
   parameter int AW     = 6,
   parameter int DW     = 32,
   parameter int RD_LAT = 1,
   parameter int TW     = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [AW-1:0]   base_addr_x_i,
   input  logic [AW-1:0]   base_addr_w_i,
   input  logic [AW-1:0]   stride_x_i,
   input  logic [AW-1:0]   stride_w_i,
   input  logic [TW-1:0]   num_tiles_i,
   output logic            csb1_x_o,
   output logic [AW-1:0]   addr1_x_o,
   input  logic [DW-1:0]   dout1_x_i,
   output logic            csb1_w_o,
   output logic [AW-1:0]   addr1_w_o,
   input  logic [DW-1:0]   dout1_w_i,
   input  logic            sa_stall_i,
   output logic            sa_start_o,
   output logic [N*DW-1:0] sa_x_o,
   output logic [N*DW-1:0] sa_w_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [TW-1:0]   tile_cnt_o
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

   state_t state, next_state;

   logic [AW-1:0]   ptr_x, ptr_w, stride_x, stride_w;
   logic [TW-1:0]   num_tiles, tile_cnt;
   logic [IW-1:0]   req_cnt;
   logic [RD_LAT-1:0] vld_pipe;
   logic [IW-1:0]   idx_pipe [RD_LAT];
   logic [N*DW-1:0] stage_x, stage_w, sa_x, sa_w;
   logic            sa_start, done;
   logic            cap_vld, last_req, last_cap, last_tile;
   logic [IW-1:0]   cap_idx;

   assign cap_vld   = vld_pipe[RD_LAT-1];
   assign cap_idx   = idx_pipe[RD_LAT-1];
   assign last_req  = (req_cnt == IW'(N - 1));
   assign last_cap  = cap_vld && (cap_idx == IW'(N - 1));
   assign last_tile = (tile_cnt == num_tiles - TW'(1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_i && num_tiles_i != '0) next_state = FETCH;
         FETCH:   if (last_req) next_state = DRAIN;
         DRAIN:   if (last_cap) next_state = COMMIT;
         COMMIT:  if (!sa_stall_i) next_state = last_tile ? IDLE : FETCH;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      csb1_x_o  = 1'b1;
      csb1_w_o  = 1'b1;
      addr1_x_o = '0;
      addr1_w_o = '0;
      busy_o    = (state != IDLE);
      if (state == FETCH) begin
         csb1_x_o  = 1'b0;
         csb1_w_o  = 1'b0;
         addr1_x_o = ptr_x;
         addr1_w_o = ptr_w;
      end
   end

   // The valid/index pipe mirrors SRAM latency so each word lands in its own lane;
   // clearing it on reset discards any data still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_x     <= '0;
         ptr_w     <= '0;
         stride_x  <= '0;
         stride_w  <= '0;
         num_tiles <= '0;
         tile_cnt  <= '0;
         req_cnt   <= '0;
         vld_pipe  <= '0;
         for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
         stage_x   <= '0;
         stage_w   <= '0;
         sa_x      <= '0;
         sa_w      <= '0;
         sa_start  <= 1'b0;
         done      <= 1'b0;
      end else begin
         sa_start    <= 1'b0;
         done        <= 1'b0;
         vld_pipe[0] <= (state == FETCH);
         idx_pipe[0] <= req_cnt;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
         if (cap_vld) begin
            stage_x[int'(cap_idx)*DW +: DW] <= dout1_x_i;
            stage_w[int'(cap_idx)*DW +: DW] <= dout1_w_i;
         end
         case (state)
            IDLE: begin
               if (start_i) begin
                  ptr_x     <= base_addr_x_i;
                  ptr_w     <= base_addr_w_i;
                  stride_x  <= stride_x_i;
                  stride_w  <= stride_w_i;
                  num_tiles <= num_tiles_i;
                  tile_cnt  <= '0;
                  req_cnt   <= '0;
                  if (num_tiles_i == '0) done <= 1'b1;
               end
            end
            FETCH: begin
               ptr_x   <= ptr_x + stride_x;
               ptr_w   <= ptr_w + stride_w;
               req_cnt <= last_req ? '0 : req_cnt + IW'(1);
            end
            COMMIT: begin
               if (!sa_stall_i) begin
                  sa_x     <= stage_x;
                  sa_w     <= stage_w;
                  sa_start <= 1'b1;
                  tile_cnt <= tile_cnt + TW'(1);
                  if (last_tile) done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sa_start_o = sa_start;
   assign done_o     = done;
   assign sa_x_o     = sa_x;
   assign sa_w_o     = sa_w;
   assign tile_cnt_o = tile_cnt;

endmodule

// File: tb/tb_spad_tile_loader.sv
// Runs two loaders (read latency 1 and 3) on shared stimulus against a cycle-indexed
// expectation table built from tile addresses, latency and the stall schedule.
module tb_spad_tile_loader;

   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int TW = 8;
   localparam int W  = 100;

   logic clk = 1'b0;
   logic rst, start_i, sa_stall_i;
   logic [AW-1:0] base_x, base_w, stride_x, stride_w;
   logic [TW-1:0] num_tiles;

   logic [1:0] csb_x, csb_w, sa_start, busy, done;
   logic [1:0][AW-1:0] ax, aw;
   logic [1:0][DW-1:0] dx, dw;
   logic [1:0][N*DW-1:0] sx, sw;
   logic [1:0][TW-1:0] cnt;
   logic [1:0][2:0][AW-1:0] px, pw;

   logic [DW-1:0] mem_x [64];
   logic [DW-1:0] mem_w [64];

   logic            exp_req   [2][W];
   logic            exp_start [2][W];
   logic            exp_done  [2][W];
   logic            exp_busy  [2][W];
   logic [AW-1:0]   exp_ax    [2][W];
   logic [AW-1:0]   exp_aw    [2][W];
   logic [TW-1:0]   exp_cnt   [2][W];
   logic [N*DW-1:0] exp_sx    [2][W];
   logic [N*DW-1:0] exp_sw    [2][W];
   logic [N*DW-1:0] held_sx   [2];
   logic [N*DW-1:0] held_sw   [2];
   logic            stall_at  [W+1];

   int n_cmp, n_fail;

   always #5 clk = ~clk;

   spad_tile_loader #(.N(N), .AW(AW), .DW(DW), .RD_LAT(1), .TW(TW)) dut0 (
      .clk(clk), .rst(rst), .start_i(start_i),
      .base_addr_x_i(base_x), .base_addr_w_i(base_w),
      .stride_x_i(stride_x), .stride_w_i(stride_w), .num_tiles_i(num_tiles),
      .csb1_x_o(csb_x[0]), .addr1_x_o(ax[0]), .dout1_x_i(dx[0]),
      .csb1_w_o(csb_w[0]), .addr1_w_o(aw[0]), .dout1_w_i(dw[0]),
      .sa_stall_i(sa_stall_i), .sa_start_o(sa_start[0]),
      .sa_x_o(sx[0]), .sa_w_o(sw[0]), .busy_o(busy[0]), .done_o(done[0]),
      .tile_cnt_o(cnt[0]));

   spad_tile_loader #(.N(N), .AW(AW), .DW(DW), .RD_LAT(3), .TW(TW)) dut1 (
      .clk(clk), .rst(rst), .start_i(start_i),
      .base_addr_x_i(base_x), .base_addr_w_i(base_w),
      .stride_x_i(stride_x), .stride_w_i(stride_w), .num_tiles_i(num_tiles),
      .csb1_x_o(csb_x[1]), .addr1_x_o(ax[1]), .dout1_x_i(dx[1]),
      .csb1_w_o(csb_w[1]), .addr1_w_o(aw[1]), .dout1_w_i(dw[1]),
      .sa_stall_i(sa_stall_i), .sa_start_o(sa_start[1]),
      .sa_x_o(sx[1]), .sa_w_o(sw[1]), .busy_o(busy[1]), .done_o(done[1]),
      .tile_cnt_o(cnt[1]));

   // SRAM models: address registered at the sampling edge, data valid RD_LAT edges later
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         px[d][0] <= ax[d];
         pw[d][0] <= aw[d];
         px[d][1] <= px[d][0];
         pw[d][1] <= pw[d][0];
         px[d][2] <= px[d][1];
         pw[d][2] <= pw[d][1];
      end
   end

   assign dx[0] = mem_x[px[0][0]];
   assign dw[0] = mem_w[pw[0][0]];
   assign dx[1] = mem_x[px[1][2]];
   assign dw[1] = mem_w[pw[1][2]];

   task automatic chk(input string tag, input int d, input int j,
                      input logic [N*DW-1:0] obs, input logic [N*DW-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", tag, d, j, obs, expv);
      end
   endtask

   // Expectation at the negedge after edge S+j (S = start edge)
   task automatic buildModel(input int d, input logic [AW-1:0] bx, input logic [AW-1:0] bw,
                             input logic [AW-1:0] stx, input logic [AW-1:0] stw,
                             input int nt, input int abort_j);
      int lat, e, c;
      logic [AW-1:0] a_x, a_w;
      logic [N*DW-1:0] tx, tw;
      lat = (d == 0) ? 1 : 3;
      tx = '0;
      tw = '0;
      for (int j = 0; j < W; j++) begin
         exp_req[d][j]   = 1'b0;
         exp_start[d][j] = 1'b0;
         exp_done[d][j]  = 1'b0;
         exp_busy[d][j]  = 1'b0;
         exp_ax[d][j]    = '0;
         exp_aw[d][j]    = '0;
         exp_cnt[d][j]   = '0;
         exp_sx[d][j]    = held_sx[d];
         exp_sw[d][j]    = held_sw[d];
      end
      if (nt == 0) exp_done[d][0] = 1'b1;
      e = 0;
      for (int t = 0; t < nt; t++) begin
         for (int i = 0; i < N; i++) begin
            a_x = AW'(int'(bx) + int'(stx) * (t*N + i));
            a_w = AW'(int'(bw) + int'(stw) * (t*N + i));
            exp_req[d][e+i] = 1'b1;
            exp_ax[d][e+i]  = a_x;
            exp_aw[d][e+i]  = a_w;
            tx[i*DW +: DW]  = mem_x[a_x];
            tw[i*DW +: DW]  = mem_w[a_w];
         end
         c = e + N + lat + 1;
         while (c < W-1 && stall_at[c]) c++;
         exp_start[d][c] = 1'b1;
         if (t == nt-1) exp_done[d][c] = 1'b1;
         for (int j = c; j < W; j++) begin
            exp_cnt[d][j] = TW'(t + 1);
            exp_sx[d][j]  = tx;
            exp_sw[d][j]  = tw;
         end
         for (int j = 0; j < c; j++) exp_busy[d][j] = 1'b1;
         e = c;
      end
      if (abort_j >= 0) begin
         for (int j = abort_j; j < W; j++) begin
            exp_req[d][j]   = 1'b0;
            exp_start[d][j] = 1'b0;
            exp_done[d][j]  = 1'b0;
            exp_busy[d][j]  = 1'b0;
            exp_cnt[d][j]   = '0;
            exp_sx[d][j]    = '0;
            exp_sw[d][j]    = '0;
         end
      end
      held_sx[d] = exp_sx[d][W-1];
      held_sw[d] = exp_sw[d][W-1];
   endtask

   task automatic checkOutput(input int j);
      for (int d = 0; d < 2; d++) begin
         chk("busy", d, j, busy[d], exp_busy[d][j]);
         chk("csb_x", d, j, csb_x[d], !exp_req[d][j]);
         chk("csb_w", d, j, csb_w[d], !exp_req[d][j]);
         if (exp_req[d][j]) begin
            chk("addr_x", d, j, ax[d], exp_ax[d][j]);
            chk("addr_w", d, j, aw[d], exp_aw[d][j]);
         end
         chk("sa_start", d, j, sa_start[d], exp_start[d][j]);
         chk("done", d, j, done[d], exp_done[d][j]);
         chk("tile_cnt", d, j, cnt[d], exp_cnt[d][j]);
         chk("sa_x", d, j, sx[d], exp_sx[d][j]);
         chk("sa_w", d, j, sw[d], exp_sw[d][j]);
      end
   endtask

   // Called at a negedge; start is sampled at the next posedge (relative cycle 0)
   task automatic applyStimulus(input logic [AW-1:0] bx, input logic [AW-1:0] bw,
                                input logic [AW-1:0] stx, input logic [AW-1:0] stw,
                                input int nt, input int abort_j, input int poke_j);
      buildModel(0, bx, bw, stx, stw, nt, abort_j);
      buildModel(1, bx, bw, stx, stw, nt, abort_j);
      base_x     = bx;
      base_w     = bw;
      stride_x   = stx;
      stride_w   = stw;
      num_tiles  = TW'(nt);
      start_i    = 1'b1;
      sa_stall_i = stall_at[0];
      @(negedge clk);
      start_i   = 1'b0;
      base_x    = AW'($urandom);
      base_w    = AW'($urandom);
      stride_x  = AW'($urandom);
      stride_w  = AW'($urandom);
      num_tiles = TW'($urandom_range(1, 9));
      for (int j = 0; j < W; j++) begin
         checkOutput(j);
         sa_stall_i = stall_at[j+1];
         start_i    = (j + 1 == poke_j);
         rst        = (j + 1 == abort_j);
         @(negedge clk);
      end
      start_i    = 1'b0;
      rst        = 1'b0;
      sa_stall_i = 1'b0;
   endtask

   task automatic clearStall();
      for (int j = 0; j <= W; j++) stall_at[j] = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      for (int i = 0; i < 64; i++) begin
         mem_x[i] = $urandom;
         mem_w[i] = $urandom;
      end
      mem_x[0] = 32'h3F800000;
      mem_x[1] = 32'h40000000;
      mem_x[2] = 32'h40400000;
      mem_x[3] = 32'h40800000;
      for (int d = 0; d < 2; d++) begin
         held_sx[d] = '0;
         held_sw[d] = '0;
      end
      clearStall();
      rst = 1'b1;
      start_i = 1'b0;
      sa_stall_i = 1'b0;
      base_x = '0;
      base_w = '0;
      stride_x = '0;
      stride_w = '0;
      num_tiles = '0;
      repeat (3) @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         chk("rst_csb_x", d, -1, csb_x[d], 1'b1);
         chk("rst_csb_w", d, -1, csb_w[d], 1'b1);
         chk("rst_addr_x", d, -1, ax[d], '0);
         chk("rst_addr_w", d, -1, aw[d], '0);
         chk("rst_busy", d, -1, busy[d], 1'b0);
         chk("rst_done", d, -1, done[d], 1'b0);
         chk("rst_start", d, -1, sa_start[d], 1'b0);
         chk("rst_cnt", d, -1, cnt[d], '0);
         chk("rst_sa_x", d, -1, sx[d], '0);
         chk("rst_sa_w", d, -1, sw[d], '0);
      end
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single tile, known FP32 data");
      applyStimulus(6'd0, 6'd8, 6'd1, 6'd1, 1, -1, -1);
      for (int d = 0; d < 2; d++)
         chk("t1_lanes", d, W, sx[d], {96'h0, 32'h3F800000} | {64'h0, 32'h40000000, 32'h0}
                                      | {32'h0, 32'h40400000, 64'h0} | {32'h40800000, 96'h0});

      $display("[TB] three tiles with address wrap");
      applyStimulus(6'd60, 6'd20, 6'd2, 6'd1, 3, -1, -1);
      for (int d = 0; d < 2; d++) chk("t2_cnt", d, W, cnt[d], TW'(3));

      $display("[TB] stall across first commit");
      for (int j = 4; j < 14; j++) stall_at[j] = 1'b1;
      applyStimulus(6'd10, 6'd30, 6'd3, 6'd5, 2, -1, -1);
      clearStall();

      $display("[TB] zero tiles, then start while busy");
      applyStimulus(6'd5, 6'd5, 6'd1, 6'd1, 0, -1, -1);
      applyStimulus(6'd12, 6'd40, 6'd1, 6'd2, 2, -1, 2);

      $display("[TB] reset during second tile fetch, then restart");
      applyStimulus(6'd0, 6'd32, 6'd1, 6'd1, 3, 9, -1);
      applyStimulus(6'd33, 6'd44, 6'd7, 6'd3, 2, -1, -1);

      $display("[TB] randomized transfers");
      repeat (6) begin
         clearStall();
         for (int j = 1; j < 48; j++) stall_at[j] = ($urandom_range(0, 3) == 0);
         applyStimulus(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                       int'($urandom_range(1, 5)), -1, int'($urandom_range(1, 6)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
